// File: rtl/pkt_rr_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter.
// Holds the word width, descriptor width, key width, the word-marker
// constants carried in data bits [133:132], the FSM state encoding and a
// tail-detect helper.
package pkt_rr_arb_pkg;

  localparam int DATA_W  = 134;
  localparam int KEY_W   = 54;
  localparam int PTYPE_W = 3;
  localparam int DESC_W  = PTYPE_W + KEY_W;

  localparam logic [1:0] MRK_HEAD = 2'b01;
  localparam logic [1:0] MRK_MID  = 2'b11;
  localparam logic [1:0] MRK_TAIL = 2'b10;

  typedef enum logic {
    IDLE_S = 1'b0,
    SEND_S = 1'b1
  } state_e;

  // Only the tail marker ends a packet; a head or middle marker never does.
  function automatic logic is_tail(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: 2] == MRK_TAIL;
  endfunction

endpackage

// File: rtl/pkt_rr_arb_if.sv
// Bundle of source-FIFO and pfw-side signals of pkt_rr_arb.
//   master : arbiter side (pops the source FIFOs, drives the pfw outputs)
//   slave  : environment side (source FIFOs, downstream almost-full, pfw sink)
// Signals:
//   src_data/src_desc/src_desc_empty : show-ahead heads of the per-source FIFOs
//   src_data_rd/src_desc_rd          : per-source pop strobes
//   in_alf                           : downstream almost full
//   out_*                            : packet words and sideband toward pfw
interface pkt_rr_arb_if
  import pkt_rr_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_data_rd;
  logic [NUM_SRC*DESC_W-1:0] src_desc;
  logic [NUM_SRC-1:0]        src_desc_empty;
  logic [NUM_SRC-1:0]        src_desc_rd;
  logic                      in_alf;
  logic [DATA_W-1:0]         out_data;
  logic                      out_data_wr;
  logic                      out_valid;
  logic                      out_valid_wr;
  logic [PTYPE_W-1:0]        out_pkttype;
  logic [KEY_W-1:0]          out_key;
  logic [NUM_SRC-1:0]        out_grant;

  modport master (
    input  src_data, src_desc, src_desc_empty, in_alf,
    output src_data_rd, src_desc_rd, out_data, out_data_wr, out_valid,
           out_valid_wr, out_pkttype, out_key, out_grant
  );

  modport slave (
    output src_data, src_desc, src_desc_empty, in_alf,
    input  src_data_rd, src_desc_rd, out_data, out_data_wr, out_valid,
           out_valid_wr, out_pkttype, out_key, out_grant
  );
endinterface

// File: rtl/pkt_rr_arb_rr_pick.sv
// Combinational round-robin picker.
//   req : per-source request
//   ptr : rotation start (first source to consider)
//   gnt : one-hot grant, 0 when no request
// With PKT_RR_ARB_PRIO0_EN defined, source 0 wins whenever it requests and
// the rotation only covers sources 1..NUM_SRC-1.
module pkt_rr_arb_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt
);

  logic [NUM_SRC-1:0] rr_req;
  logic [PTR_W:0]     idx;
  logic               found;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
`ifdef PKT_RR_ARB_PRIO0_EN
    rr_req = {req[NUM_SRC-1:1], 1'b0};
`else
    rr_req = req;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      // Cyclic index ptr+i, wrapped without a modulo operator.
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_SRC)) idx = idx - (PTR_W+1)'(NUM_SRC);
      if (!found && rr_req[idx[PTR_W-1:0]]) begin
        gnt[idx[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
`ifdef PKT_RR_ARB_PRIO0_EN
    if (req[0]) gnt = {{(NUM_SRC-1){1'b0}}, 1'b1};
`endif
  end

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-granular round-robin arbiter: merges NUM_SRC buffered packet
// streams into the single pfw input, one whole packet at a time, with one
// idle (grant) cycle between packets. Downstream almost-full only blocks new
// grants; a started packet always completes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pkt_rr_arb_if.master (source FIFOs in, pfw outputs out)
// Build option: PKT_RR_ARB_PRIO0_EN gives source 0 strict priority.
module pkt_rr_arb
  import pkt_rr_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pkt_rr_arb_if.master  bus
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic [NUM_SRC-1:0]   out_grant_q, out_grant_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_data_wr_q, out_data_wr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_valid_wr_q, out_valid_wr_d;
  logic [PTYPE_W-1:0]   out_pkttype_q, out_pkttype_d;
  logic [KEY_W-1:0]     out_key_q, out_key_d;

  logic [NUM_SRC-1:0]   req, pick_gnt, data_rd, desc_rd;
  logic [PTR_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    src_word [NUM_SRC];
  logic [DESC_W-1:0]    src_dsc  [NUM_SRC];
  logic [DATA_W-1:0]    cur_word;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_split
    assign src_word[i] = bus.src_data[i*DATA_W +: DATA_W];
    assign src_dsc[i]  = bus.src_desc[i*DESC_W +: DESC_W];
  end

  assign req      = ~bus.src_desc_empty & {NUM_SRC{~bus.in_alf}};
  assign cur_word = src_word[gnt_idx_q];

  pkt_rr_arb_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_idx_d      = gnt_idx_q;
    out_grant_d    = out_grant_q;
    out_data_d     = out_data_q;
    out_data_wr_d  = 1'b0;
    out_valid_d    = 1'b0;
    out_valid_wr_d = 1'b0;
    out_pkttype_d  = out_pkttype_q;
    out_key_d      = out_key_q;
    data_rd        = '0;
    desc_rd        = '0;
    case (state_q)
      IDLE_S: begin
        // Owner stays visible through the tail-word cycle, then follows the
        // new grant (or clears when nothing is requesting).
        out_grant_d = pick_gnt;
        if (|req) begin
          gnt_idx_d                    = pick_idx;
          desc_rd                      = pick_gnt;
          {out_pkttype_d, out_key_d}   = src_dsc[pick_idx];
          state_d                      = SEND_S;
        end
      end
      SEND_S: begin
        data_rd[gnt_idx_q] = 1'b1;
        out_data_d         = cur_word;
        out_data_wr_d      = 1'b1;
        if (is_tail(cur_word)) begin
          out_valid_d    = 1'b1;
          out_valid_wr_d = 1'b1;
          state_d        = IDLE_S;
`ifdef PKT_RR_ARB_PRIO0_EN
          // Source-0 grants bypass the rotation and leave it untouched.
          if (gnt_idx_q != '0)
`endif
          rr_ptr_d = (gnt_idx_q == PTR_W'(NUM_SRC-1)) ? '0 : gnt_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE_S;
      rr_ptr_q       <= '0;
      gnt_idx_q      <= '0;
      out_grant_q    <= '0;
      out_data_q     <= '0;
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
      out_pkttype_q  <= '0;
      out_key_q      <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      out_grant_q    <= out_grant_d;
      out_data_q     <= out_data_d;
      out_data_wr_q  <= out_data_wr_d;
      out_valid_q    <= out_valid_d;
      out_valid_wr_q <= out_valid_wr_d;
      out_pkttype_q  <= out_pkttype_d;
      out_key_q      <= out_key_d;
    end
  end

  assign bus.src_data_rd  = data_rd;
  // The descriptor pop comes straight from the request inputs, so it is
  // forced low while reset is held to keep every output at 0.
  assign bus.src_desc_rd  = desc_rd & {NUM_SRC{rst_n}};
  assign bus.out_data     = out_data_q;
  assign bus.out_data_wr  = out_data_wr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_valid_wr = out_valid_wr_q;
  assign bus.out_pkttype  = out_pkttype_q;
  assign bus.out_key      = out_key_q;
  assign bus.out_grant    = out_grant_q;

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Self-checking bench for pkt_rr_arb: source FIFOs modelled with queues, a
// packet-level arbitration model predicting every descriptor pop and output
// word with its cycle, and a negedge monitor comparing against the model.
module tb_pkt_rr_arb;
  import pkt_rr_arb_pkg::*;

  localparam int NUM_SRC  = 4;
  localparam int MAX_PKTS = 1024;
`ifdef PKT_RR_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef struct packed {
    int                 cyc;
    logic [NUM_SRC-1:0] gnt;
  } exp_desc_t;

  typedef struct packed {
    int                 cyc;
    logic [NUM_SRC-1:0] gnt;
    logic [PTYPE_W-1:0] pt;
    logic [KEY_W-1:0]   key;
    logic [DATA_W-1:0]  w;
    logic               tail;
  } exp_word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_rr_arb_if #(.NUM_SRC(NUM_SRC)) bus ();

  pkt_rr_arb #(.NUM_SRC(NUM_SRC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Source FIFOs (stimulus side).
  logic [DATA_W-1:0] fifo_data [NUM_SRC][$];
  logic [DESC_W-1:0] fifo_desc [NUM_SRC][$];

  // Packet store and reference model state.
  logic [DATA_W-1:0] pkt_words [MAX_PKTS][8];
  int                pkt_len   [MAX_PKTS];
  logic [DESC_W-1:0] pkt_desc  [MAX_PKTS];
  int                pkt_cnt = 0;
  int                m_pend [NUM_SRC][$];
  int                m_ptr   = 0;
  int                free_at = 0;
  int                cyc     = 0;

  exp_desc_t exp_d [$];
  exp_word_t exp_w [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 'h%0h expected 'h%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_data[i*DATA_W +: DATA_W] = (fifo_data[i].size() > 0) ? fifo_data[i][0] : '0;
      bus.src_desc[i*DESC_W +: DESC_W] = (fifo_desc[i].size() > 0) ? fifo_desc[i][0] : '0;
      bus.src_desc_empty[i]            = (fifo_desc[i].size() == 0);
    end
  endtask

  task automatic push_pkt(input int src, input int len, input logic [PTYPE_W-1:0] pt,
                          input logic [KEY_W-1:0] key, input bit odd_head);
    logic [131:0]      r;
    logic [1:0]        mrk;
    logic [DATA_W-1:0] w;
    int                id;
    id = pkt_cnt++;
    r  = '0;
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < 5; j++) r = {r[99:0], $urandom()};
      if (k == len - 1)  mrk = MRK_TAIL;
      else if (k == 0)   mrk = odd_head ? MRK_MID : MRK_HEAD;
      else               mrk = MRK_MID;
      w = {mrk, r};
      pkt_words[id][k] = w;
      fifo_data[src].push_back(w);
    end
    pkt_len[id]  = len;
    pkt_desc[id] = {pt, key};
    fifo_desc[src].push_back({pt, key});
    m_pend[src].push_back(id);
    drive_inputs();
  endtask

  task automatic push_rand(input int src);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    push_pkt(src, $urandom_range(1, 6), t[56:54], t[53:0], ($urandom_range(0, 7) == 0));
  endtask

  // Packet-level model: when free, grant the next requesting source in
  // rotation order; a packet of L words occupies the grant cycle plus L
  // transfer cycles and its words appear 2..L+1 cycles after the grant.
  task automatic model_step();
    logic [NUM_SRC-1:0] req;
    int g, s, id;
    exp_desc_t d;
    exp_word_t e;
    if (!rst_n || cyc < free_at) return;
    for (int i = 0; i < NUM_SRC; i++) req[i] = (m_pend[i].size() > 0) && !bus.in_alf;
    if (req == '0) return;
    g = -1;
    if (PRIO0 && req[0]) g = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (m_ptr + k) % NUM_SRC;
      if (g < 0 && req[s] && !(PRIO0 && s == 0)) g = s;
    end
    id    = m_pend[g].pop_front();
    d.cyc = cyc;
    d.gnt = NUM_SRC'(1) << g;
    exp_d.push_back(d);
    for (int k = 0; k < pkt_len[id]; k++) begin
      e.cyc          = cyc + 2 + k;
      e.gnt          = d.gnt;
      {e.pt, e.key}  = pkt_desc[id];
      e.w            = pkt_words[id][k];
      e.tail         = (k == pkt_len[id] - 1);
      exp_w.push_back(e);
    end
    free_at = cyc + pkt_len[id] + 1;
    if (!(PRIO0 && g == 0)) m_ptr = (g + 1) % NUM_SRC;
  endtask

  task automatic tick();
    logic [NUM_SRC-1:0] rd_data, rd_desc;
    model_step();
    @(negedge clk);
    rd_data = bus.src_data_rd;
    rd_desc = bus.src_desc_rd;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rd_data[i] && fifo_data[i].size() > 0) void'(fifo_data[i].pop_front());
      if (rd_desc[i] && fifo_desc[i].size() > 0) void'(fifo_desc[i].pop_front());
    end
    drive_inputs();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NUM_SRC; i++) if (m_pend[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_w.size() > 0 || exp_d.size() > 0 || any_pend()) && n < 2000) begin
      tick();
      n++;
    end
    check(name, 256'(n < 2000), 256'(1));
  endtask

  task automatic reset_model();
    exp_w.delete();
    exp_d.delete();
    for (int i = 0; i < NUM_SRC; i++) begin
      fifo_data[i].delete();
      fifo_desc[i].delete();
      m_pend[i].delete();
    end
    m_ptr   = 0;
    free_at = 0;
    drive_inputs();
  endtask

  function automatic logic [255:0] all_outputs();
    return 256'({bus.out_data, bus.out_data_wr, bus.out_valid, bus.out_valid_wr,
                 bus.out_pkttype, bus.out_key, bus.out_grant,
                 bus.src_data_rd, bus.src_desc_rd});
  endfunction

  // Monitor: every cycle compare descriptor pops and output words with the
  // model's predictions for that exact cycle.
  task automatic monitor();
    logic [NUM_SRC-1:0] e_rd;
    logic               e_wr;
    exp_desc_t          d;
    exp_word_t          e;
    e_rd = '0;
    if (exp_d.size() > 0 && exp_d[0].cyc == cyc) begin
      d    = exp_d.pop_front();
      e_rd = d.gnt;
    end
    check("src_desc_rd", 256'(bus.src_desc_rd), 256'(e_rd));
    e_wr = (exp_w.size() > 0 && exp_w[0].cyc == cyc);
    check("out_data_wr", 256'(bus.out_data_wr), 256'(e_wr));
    if (e_wr) begin
      e = exp_w.pop_front();
      check("out_data",     256'(bus.out_data),     256'(e.w));
      check("out_grant",    256'(bus.out_grant),    256'(e.gnt));
      check("out_pkttype",  256'(bus.out_pkttype),  256'(e.pt));
      check("out_key",      256'(bus.out_key),      256'(e.key));
      check("out_valid_wr", 256'(bus.out_valid_wr), 256'(e.tail));
      if (e.tail) check("out_valid", 256'(bus.out_valid), 256'(1));
    end else begin
      check("out_valid_wr_idle", 256'(bus.out_valid_wr), 256'(0));
    end
  endtask

  always @(negedge clk) if (rst_n) monitor();

  int target;
  int n;

  initial begin
    rst_n      = 1'b0;
    bus.in_alf = 1'b0;
    reset_model();
    #1;
    check("reset_outputs", all_outputs(), '0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // All four sources with two packets each: strict rotation, no interleave.
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM_SRC; s++) push_rand(s);
    drain("drain_all_sources");

    // Single 4-word packet on source 2.
    push_pkt(2, 4, 3'd1, 54'h12345, 1'b0);
    drain("drain_single");

    // Almost-full before the grant blocks it; raised mid-packet it does not.
    bus.in_alf = 1'b1;
    push_pkt(1, 6, 3'd2, 54'h111, 1'b0);
    push_pkt(0, 5, 3'd3, 54'h222, 1'b0);
    repeat (8) tick();
    check("alf_no_grant", 256'(bus.out_grant), 256'(0));
    bus.in_alf = 1'b0;
    repeat (3) tick();
    bus.in_alf = 1'b1;
    repeat (12) tick();
    bus.in_alf = 1'b0;
    drain("drain_alf");

    // Descriptor fields held from head to tail and until the next grant.
    push_pkt(3, 5, 3'd5, 54'h3F_0123_4567_89AB, 1'b0);
    drain("drain_key");
    repeat (4) tick();
    check("out_key_hold",     256'(bus.out_key),     256'(54'h3F_0123_4567_89AB));
    check("out_pkttype_hold", 256'(bus.out_pkttype), 256'(3'd5));

    // Sources 0 and 1 kept pending, then sources 1 and 2.
    for (int t = 0; t < 60; t++) begin
      if (m_pend[0].size() < 2) push_rand(0);
      if (m_pend[1].size() < 2) push_rand(1);
      tick();
    end
    for (int t = 0; t < 40; t++) begin
      if (m_pend[1].size() < 2) push_rand(1);
      if (m_pend[2].size() < 2) push_rand(2);
      tick();
    end
    drain("drain_prio");

    // Randomised traffic with almost-full toggling.
    for (int t = 0; t < 400; t++) begin
      int s;
      s = $urandom_range(0, NUM_SRC - 1);
      if ($urandom_range(0, 2) == 0 && m_pend[s].size() < 3) push_rand(s);
      if ($urandom_range(0, 9) == 0) bus.in_alf = ~bus.in_alf;
      tick();
    end
    bus.in_alf = 1'b0;
    drain("drain_random");

    // Reset during the 3rd word of a 6-word packet; rotation must restart at 0.
    push_pkt(2, 3, 3'd4, 54'h333, 1'b0);
    drain("drain_pre_reset");
    push_pkt(1, 6, 3'd6, 54'h444, 1'b0);
    n = 0;
    while (exp_w.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    check("grant_before_reset", 256'(exp_w.size()), 256'(6));
    target = (exp_w.size() >= 3) ? exp_w[2].cyc : cyc;
    while (cyc < target) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midpkt_reset_outputs", all_outputs(), '0);
    reset_model();
    repeat (2) tick();
    rst_n = 1'b1;
    push_pkt(3, 2, 3'd7, 54'h555, 1'b0);
    push_pkt(2, 2, 3'd0, 54'h666, 1'b0);
    drain("drain_post_reset");

    check("leftover_words", 256'(exp_w.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
